// File: rtl/prog_clk_div.sv
// Runtime-programmable clock divider with a 50%-duty ClkOut, a Tick at each rising edge,
// glitch-free divisor switching at full-period boundaries, and a counted burst mode.
module prog_clk_div #(
  parameter int          CNT_W       = 29,
  parameter int unsigned DEFAULT_DIV = 50000000,
  parameter int          BURST_W     = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               En,
  input  logic               Mode,
  input  logic               LdValid,
  input  logic [CNT_W-1:0]   LdDiv,
  output logic               LdReady,
  input  logic               BurstStart,
  input  logic [BURST_W-1:0] BurstLen,
  output logic               ClkOut,
  output logic               Tick,
  output logic               Done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BURST = 2'd2} state_t;

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   div_act, div_pend;
  logic               pend_flag;
  logic [BURST_W-1:0] burst_cnt, burst_cnt_nxt;
  logic               clk_nxt, tick_nxt, done_nxt;
  logic               running, at_top, rise, boundary;
  logic               burst_end, zero_burst, accept, apply;

  assign running    = (state != IDLE);
  assign at_top     = (cnt == div_act);
  assign rise       = running & at_top & ~ClkOut;
  // Falling toggle closes a full period: the only place a new divisor may take over.
  assign boundary   = running & at_top & ClkOut;
  assign burst_end  = (state == BURST) & boundary & (burst_cnt == '0);
  assign zero_burst = (state == IDLE) & En & Mode & BurstStart & (BurstLen == '0);
  assign accept     = LdValid & ~pend_flag;
  assign apply      = pend_flag & ((state == IDLE) | (boundary & En));
  assign LdReady    = ~pend_flag;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!En) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!Mode)                              state_nxt = RUN;
          else if (BurstStart && BurstLen != '0)  state_nxt = BURST;
        end
        RUN:     if (boundary && Mode) state_nxt = IDLE;
        BURST:   if (burst_end)        state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_nxt       = cnt;
    clk_nxt       = ClkOut;
    tick_nxt      = 1'b0;
    done_nxt      = zero_burst | (En & burst_end);
    burst_cnt_nxt = burst_cnt;
    if (state_nxt == IDLE || state == IDLE) begin
      cnt_nxt = '0;
      clk_nxt = 1'b0;
      if (state == IDLE && state_nxt == BURST) burst_cnt_nxt = BurstLen;
    end else if (at_top) begin
      cnt_nxt  = '0;
      clk_nxt  = ~ClkOut;
      tick_nxt = ~ClkOut;
      if (rise && state == BURST) burst_cnt_nxt = burst_cnt - BURST_W'(1);
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt       <= '0;
      ClkOut    <= 1'b0;
      Tick      <= 1'b0;
      Done      <= 1'b0;
      burst_cnt <= '0;
    end else begin
      cnt       <= cnt_nxt;
      ClkOut    <= clk_nxt;
      Tick      <= tick_nxt;
      Done      <= done_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // A load equal to the active divisor is a no-op, so it never blocks the next request.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      div_act   <= DIV_RST;
      pend_flag <= 1'b0;
    end else if (apply) begin
      div_act   <= div_pend;
      pend_flag <= 1'b0;
    end else if (accept && LdDiv != div_act) begin
      pend_flag <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (accept && LdDiv != div_act) div_pend <= LdDiv;
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// Bench for prog_clk_div: directed steps plus random traffic, checked each cycle against
// a phase-arithmetic model of the divided clock.
module tb_prog_clk_div;
  localparam int CNT_W   = 16;
  localparam int DEF     = 3;
  localparam int BURST_W = 8;

  logic               clk = 1'b0;
  logic               rst, en, mode, ld_valid, bstart;
  logic [CNT_W-1:0]   ld_div;
  logic [BURST_W-1:0] blen;
  logic               ld_ready, clk_out, tick, done;

  prog_clk_div #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF), .BURST_W(BURST_W)) dut (
    .Clk(clk), .Rst(rst), .En(en), .Mode(mode), .LdValid(ld_valid), .LdDiv(ld_div),
    .LdReady(ld_ready), .BurstStart(bstart), .BurstLen(blen),
    .ClkOut(clk_out), .Tick(tick), .Done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int tick_seen = 0;
  int done_seen = 0;

  // Model: while running, the output phase is a pure function of cycles since origin.
  bit m_run, m_burst, m_pend_v, m_done, m_clk_exp, m_tick_exp;
  int m_origin, m_d, m_pend, m_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_burst = 0; m_pend_v = 0; m_done = 0;
    m_d = DEF; m_left = 0; m_origin = 0; m_pend = 0;
  endtask

  task automatic model_step();
    int  p, k, per, d_pre;
    bit  was_run, is_rise, is_bnd, pend_pre;
    p        = cyc_n - 1;
    was_run  = m_run;
    d_pre    = m_d;
    pend_pre = m_pend_v;
    per      = 2 * (m_d + 1);
    k        = p - m_origin;
    is_rise  = was_run && (k % per == m_d);
    is_bnd   = was_run && (k % per == per - 1);
    m_done   = 0;
    if (!was_run && m_pend_v) begin
      m_d = m_pend; m_pend_v = 0;
    end
    if (!en) begin
      m_run = 0;
    end else if (!was_run) begin
      if (!mode) begin
        m_run = 1; m_burst = 0; m_origin = cyc_n;
      end else if (bstart) begin
        if (blen == 0) m_done = 1;
        else begin
          m_run = 1; m_burst = 1; m_left = int'(blen); m_origin = cyc_n;
        end
      end
    end else begin
      if (is_rise && m_burst) m_left--;
      if (is_bnd) begin
        if (m_pend_v) begin
          m_d = m_pend; m_pend_v = 0;
        end
        m_origin = cyc_n;
        if (m_burst ? (m_left == 0) : mode) begin
          m_run = 0;
          if (m_burst) m_done = 1;
        end
      end
    end
    if (ld_valid && !pend_pre && int'(ld_div) != d_pre) begin
      m_pend_v = 1; m_pend = int'(ld_div);
    end
  endtask

  task automatic cyc();
    int k, per;
    @(posedge clk);
    #1;
    cyc_n++;
    if (rst) model_reset();
    else     model_step();
    m_clk_exp = 0; m_tick_exp = 0;
    if (m_run) begin
      k   = cyc_n - m_origin;
      per = 2 * (m_d + 1);
      m_clk_exp  = ((k / (m_d + 1)) % 2) == 1;
      m_tick_exp = (k % per) == (m_d + 1);
    end
    chk("clk_out",  32'(clk_out),  32'(m_clk_exp));
    chk("tick",     32'(tick),     32'(m_tick_exp));
    chk("done",     32'(done),     32'(m_done));
    chk("ld_ready", 32'(ld_ready), 32'(!m_pend_v));
    if (tick === 1'b1) tick_seen++;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse_load(input int d);
    ld_valid = 1'b1;
    ld_div   = CNT_W'(d);
    cyc();
    ld_valid = 1'b0;
  endtask

  task automatic do_burst(input int b, input int d);
    bstart = 1'b1;
    blen   = BURST_W'(b);
    tick_seen = 0; done_seen = 0;
    cyc();
    bstart = 1'b0;
    run(2 * (d + 1) * b + 4);
    chk("burst_ticks", 32'(tick_seen), 32'(b));
    chk("burst_done",  32'(done_seen), 32'd1);
  endtask

  initial begin
    int d, b;
    rst = 1'b1; en = 1'b0; mode = 1'b0; ld_valid = 1'b0; bstart = 1'b0;
    ld_div = '0; blen = '0;
    model_reset();
    run(2);
    rst = 1'b0;

    // Continuous run at the default divisor.
    en = 1'b1;
    run(20);

    // Slow-to-fast switch requested mid high phase.
    for (int i = 0; i < 16; i++) begin
      if (m_clk_exp) break;
      cyc();
    end
    pulse_load(1);
    run(20);

    // Clk/2 output.
    pulse_load(0);
    run(12);

    // Random loads while running, some while not ready.
    repeat (30) begin
      run($urandom_range(0, 6));
      pulse_load($urandom_range(0, 5));
    end
    run(12);

    // Leave RUN through Mode, then bursts.
    mode = 1'b1;
    run(30);
    pulse_load(1);
    run(2);
    do_burst(3, m_d);
    do_burst(0, m_d);
    repeat (6) begin
      d = $urandom_range(0, 3);
      pulse_load(d);
      run(2);
      b = $urandom_range(0, 5);
      do_burst(b, m_d);
    end

    // Abort a burst with En, then load while disabled.
    bstart = 1'b1; blen = 8'd10;
    cyc();
    bstart = 1'b0;
    run(7);
    en = 1'b0;
    done_seen = 0;
    run(4);
    chk("abort_no_done", 32'(done_seen), 32'd0);
    pulse_load(4);
    run(3);
    en = 1'b1;

    // Fully random traffic.
    repeat (150) begin
      en       = ($urandom_range(0, 15) != 0);
      mode     = ($urandom_range(0, 3) == 0);
      bstart   = 1'($urandom_range(0, 1));
      blen     = BURST_W'($urandom_range(0, 3));
      ld_valid = ($urandom_range(0, 3) == 0);
      ld_div   = CNT_W'($urandom_range(0, 4));
      cyc();
    end
    bstart = 1'b0; ld_valid = 1'b0;

    // Asynchronous reset mid-RUN with a divisor pending, taken while ClkOut is high.
    en = 1'b1; mode = 1'b0;
    run(4);
    for (int i = 0; i < 40; i++) begin
      if (!m_clk_exp && !m_pend_v && m_run) break;
      cyc();
    end
    pulse_load((m_d == 2) ? 1 : 2);
    for (int i = 0; i < 16; i++) begin
      if (m_clk_exp) break;
      cyc();
    end
    chk("pre_rst_ready", 32'(ld_ready), 32'(!m_pend_v));
    #2;
    rst = 1'b1;
    #1;
    chk("async_clk_out",  32'(clk_out),  32'd0);
    chk("async_tick",     32'(tick),     32'd0);
    chk("async_done",     32'(done),     32'd0);
    chk("async_ld_ready", 32'(ld_ready), 32'd1);
    run(2);
    rst = 1'b0;
    run(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
